vga_bounce_renderer: RTL and testbench
======================================

Name: vga_bounce_renderer

Overview:
- Pixel-colour stage directly downstream of the VGA timing generator, clocked on the same dot clock.
- Consumes that generator's x/y coordinates, which carry out-of-area sentinels of 640 and 480, plus its hsync/vsync.
- Renders a bordered square on a background; the square moves once per frame, bounces off the screen edges and changes colour on every bounce.
- Drives registered 8-bit RGB and delay-matched syncs to the pins.

Parameters:
- H_VISIBLE, 640, visible width; x_val >= this means blanking.
- V_VISIBLE, 480, visible height; y_val >= this means blanking.
- BOX_SIZE, 32, square edge in pixels.
- BORDER, 2, border ring thickness in pixels.
- STEP, 2, pixels moved per frame on each axis.
- BG_RGB, 24'h000040, background colour {r,g,b}.

Ports:
- clk  in  1  dot clock.
- rst_n  in  1  synchronous active-low reset.
- x_val  in  10  pixel column from timing stage.
- y_val  in  10  pixel row from timing stage.
- hsync_in  in  1  hsync from timing stage.
- vsync_in  in  1  vsync from timing stage (active low).
- enable  in  1  1 = motion enabled; 0 = square frozen.
- hsync_out  out  1  hsync_in delayed 1 clk.
- vsync_out  out  1  vsync_in delayed 1 clk.
- red  out  8  pixel red.
- green  out  8  pixel green.
- blue  out  8  pixel blue.
- frame_count  out  16  frames seen, wraps.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-low, rst_n. All state updates on posedge clk only.
- Reset values:
  - red, green, blue = 0; hsync_out = 1; vsync_out = 1.
  - Internal vsync_d = 1, so no spurious frame tick after reset.
  - box_x = 0, box_y = 0; dir_x = +, dir_y = +; color_idx = 0; frame_count = 0.
- Reset asserted mid-frame: outputs take reset values on the next edge.
- Frame tick: frame_tick = vsync_d & ~vsync_in (falling edge); vsync_d <= vsync_in every clk. vsync held low for many cycles gives exactly one tick.
- frame_count: increments on every tick regardless of enable; wraps 0xFFFF -> 0.
- Motion on tick with enable = 1, per axis, shown for x (y identical with V_VISIBLE); 11-bit internal arithmetic, no wrap:
  - dir + and box_x + STEP >= H_VISIBLE - BOX_SIZE: box_x <= H_VISIBLE - BOX_SIZE; dir <= -; bounce.
  - dir + otherwise: box_x <= box_x + STEP.
  - dir - and box_x <= STEP: box_x <= 0; dir <= +; bounce.
  - dir - otherwise: box_x <= box_x - STEP.
- Colour on bounce: any bounce (x, y, or both in the same tick, i.e. a corner) increments color_idx by exactly 1, 3 bits, wrapping 7 -> 0.
- enable = 0: position, direction and color_idx hold; the square is still drawn.
- Palette (color_idx -> rgb): 0 FF0000, 1 00FF00, 2 0000FF, 3 FFFF00, 4 00FFFF, 5 FF00FF, 6 FFFFFF, 7 FF8000.
- Pixel select (combinational from x_val, y_val and current registers), priority order:
  1. x_val >= H_VISIBLE or y_val >= V_VISIBLE -> 000000.
  2. Inside box, i.e. box_x <= x_val < box_x + BOX_SIZE and same for y:
     - dx = x_val - box_x, dy = y_val - box_y.
     - Border if dx < BORDER, dx >= BOX_SIZE - BORDER, dy < BORDER or dy >= BOX_SIZE - BORDER -> FFFFFF.
     - Otherwise -> palette[color_idx].
  3. Else -> BG_RGB.
- Latency:
  - RGB registered: 1 clk from x_val/y_val.
  - hsync_out/vsync_out also delayed 1 clk, so sync and colour stay aligned.
- No tearing: ticks occur during vertical sync, which lies outside the visible area, so position never changes while visible pixels are drawn.

Test Plan:
- Reset, then x_val=0,y_val=0 / 10,10 / 100,100 -> one clk later RGB = FFFFFF / FF0000 / 000040; hsync_out=vsync_out=1 during reset.
- x_val=640,y_val=100, and x_val=100,y_val=480 -> RGB 000000 both; hsync_in toggled -> hsync_out follows 1 clk later.
- One vsync_in 1->0 edge with enable=1 -> box at (2,2), frame_count=1; pixel (1,1) -> 000040, (2,2) -> FFFFFF.
- 224 ticks from reset -> box_y=448, dir_y -, color_idx=1, interior pixel 00FF00. 304 ticks -> box_x=608, box_y=288, color_idx=2, interior 0000FF.
- enable=0 for 10 ticks -> box position and colour unchanged, frame_count +10. vsync_in held low 1000 clks -> frame_count +1 only.
- Assert rst_n=0 mid-frame after 50 ticks -> next clk RGB 000000, box (0,0), frame_count 0. Release -> first vsync_in low produces no tick until a real 1->0 edge.

Source files
------------

// File: rtl/vga_bounce_renderer_if.sv
// Pixel-stage bus: timing-generator coordinates and syncs in, registered colour and syncs out.
interface vga_bounce_renderer_if;
    logic [9:0]  x_val;
    logic [9:0]  y_val;
    logic        hsync_in;
    logic        vsync_in;
    logic        enable;
    logic        hsync_out;
    logic        vsync_out;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic [15:0] frame_count;

    modport master (
        output x_val, y_val, hsync_in, vsync_in, enable,
        input  hsync_out, vsync_out, red, green, blue, frame_count
    );

    modport slave (
        input  x_val, y_val, hsync_in, vsync_in, enable,
        output hsync_out, vsync_out, red, green, blue, frame_count
    );
endinterface

// File: rtl/vga_bounce_renderer.sv
// Draws a bordered square bouncing around the visible area, moving once per frame and
// changing colour on every bounce; RGB and syncs are registered together for alignment.
module vga_bounce_renderer #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned BORDER    = 2,
    parameter int unsigned STEP      = 2,
    parameter logic [23:0] BG_RGB    = 24'h000040
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_bounce_renderer_if.slave  bus
);
    typedef enum logic {DIR_POS, DIR_NEG} dir_t;

    localparam logic [10:0] X_MAX    = 11'(H_VISIBLE - BOX_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(V_VISIBLE - BOX_SIZE);
    localparam logic [10:0] STEP11   = 11'(STEP);
    localparam logic [10:0] BOX11    = 11'(BOX_SIZE);
    localparam logic [10:0] BORDER11 = 11'(BORDER);
    localparam logic [10:0] HVIS11   = 11'(H_VISIBLE);
    localparam logic [10:0] VVIS11   = 11'(V_VISIBLE);

    logic [9:0]  box_x, box_y;
    logic [9:0]  box_x_next, box_y_next;
    dir_t        dir_x, dir_y, dir_x_next, dir_y_next;
    logic        bounce_x, bounce_y;
    logic [2:0]  color_idx;
    logic        vsync_d;
    logic        frame_tick;
    logic [10:0] x_ext, y_ext, px, py, dx, dy;
    logic        in_box, on_border;
    logic [23:0] palette_rgb, pixel_rgb;

    assign x_ext      = {1'b0, box_x};
    assign y_ext      = {1'b0, box_y};
    assign frame_tick = vsync_d & ~bus.vsync_in;

    // Clamp to the edge on the step that would reach or cross it, so positions never wrap.
    always_comb begin
        box_x_next = box_x;
        dir_x_next = dir_x;
        bounce_x   = 1'b0;
        if (dir_x == DIR_POS) begin
            if (x_ext + STEP11 >= X_MAX) begin
                box_x_next = X_MAX[9:0];
                dir_x_next = DIR_NEG;
                bounce_x   = 1'b1;
            end else begin
                box_x_next = 10'(x_ext + STEP11);
            end
        end else begin
            if (x_ext <= STEP11) begin
                box_x_next = '0;
                dir_x_next = DIR_POS;
                bounce_x   = 1'b1;
            end else begin
                box_x_next = 10'(x_ext - STEP11);
            end
        end

        box_y_next = box_y;
        dir_y_next = dir_y;
        bounce_y   = 1'b0;
        if (dir_y == DIR_POS) begin
            if (y_ext + STEP11 >= Y_MAX) begin
                box_y_next = Y_MAX[9:0];
                dir_y_next = DIR_NEG;
                bounce_y   = 1'b1;
            end else begin
                box_y_next = 10'(y_ext + STEP11);
            end
        end else begin
            if (y_ext <= STEP11) begin
                box_y_next = '0;
                dir_y_next = DIR_POS;
                bounce_y   = 1'b1;
            end else begin
                box_y_next = 10'(y_ext - STEP11);
            end
        end
    end

    always_comb begin
        unique case (color_idx)
            3'd0:    palette_rgb = 24'hFF0000;
            3'd1:    palette_rgb = 24'h00FF00;
            3'd2:    palette_rgb = 24'h0000FF;
            3'd3:    palette_rgb = 24'hFFFF00;
            3'd4:    palette_rgb = 24'h00FFFF;
            3'd5:    palette_rgb = 24'hFF00FF;
            3'd6:    palette_rgb = 24'hFFFFFF;
            default: palette_rgb = 24'hFF8000;
        endcase
    end

    always_comb begin
        px        = {1'b0, bus.x_val};
        py        = {1'b0, bus.y_val};
        dx        = px - x_ext;
        dy        = py - y_ext;
        in_box    = (px >= x_ext) && (px < x_ext + BOX11) &&
                    (py >= y_ext) && (py < y_ext + BOX11);
        on_border = (dx < BORDER11) || (dx >= BOX11 - BORDER11) ||
                    (dy < BORDER11) || (dy >= BOX11 - BORDER11);
        pixel_rgb = BG_RGB;
        if (px >= HVIS11 || py >= VVIS11) begin
            pixel_rgb = '0;
        end else if (in_box) begin
            pixel_rgb = on_border ? 24'hFFFFFF : palette_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d         <= 1'b1;
            bus.hsync_out   <= 1'b1;
            bus.vsync_out   <= 1'b1;
            bus.red         <= '0;
            bus.green       <= '0;
            bus.blue        <= '0;
            bus.frame_count <= '0;
            box_x           <= '0;
            box_y           <= '0;
            dir_x           <= DIR_POS;
            dir_y           <= DIR_POS;
            color_idx       <= '0;
        end else begin
            vsync_d       <= bus.vsync_in;
            bus.hsync_out <= bus.hsync_in;
            bus.vsync_out <= bus.vsync_in;
            {bus.red, bus.green, bus.blue} <= pixel_rgb;
            if (frame_tick) begin
                bus.frame_count <= bus.frame_count + 16'd1;
                if (bus.enable) begin
                    box_x     <= box_x_next;
                    box_y     <= box_y_next;
                    dir_x     <= dir_x_next;
                    dir_y     <= dir_y_next;
                    // A corner hit bounces both axes but advances the colour only once.
                    color_idx <= color_idx + 3'(bounce_x | bounce_y);
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Bench for vga_bounce_renderer: fixed vector table, frame-tick sequences and random pixel probes
// compared against a closed-form triangle-wave model of the square's motion.
module tb_vga_bounce_renderer;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    vga_bounce_renderer_if bus();

    vga_bounce_renderer #(
        .H_VISIBLE (640),
        .V_VISIBLE (480),
        .BOX_SIZE  (32),
        .BORDER    (2),
        .STEP      (2),
        .BG_RGB    (24'h000040)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state: enabled ticks since reset and frames since reset.
    int moves  = 0;
    int frames = 0;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
    } vec_t;
    vec_t vecs[8];

    function automatic int tri_pos(int n, int span);
        int t;
        t = (n * 2) % (2 * span);
        return (t <= span) ? t : 2 * span - t;
    endfunction

    function automatic int color_of(int n);
        int c = 0;
        for (int k = 1; k <= n; k++)
            if (((2 * k) % 608 == 0) || ((2 * k) % 448 == 0)) c++;
        return c % 8;
    endfunction

    function automatic logic [23:0] palette(int idx);
        logic [23:0] p[8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                              24'h00FFFF, 24'hFF00FF, 24'hFFFFFF, 24'hFF8000};
        return p[idx];
    endfunction

    function automatic logic [23:0] model_rgb(int x, int y);
        int bx, by, dx, dy;
        if (x >= 640 || y >= 480) return 24'h000000;
        bx = tri_pos(moves, 608);
        by = tri_pos(moves, 448);
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) begin
            dx = x - bx;
            dy = y - by;
            if (dx < 2 || dx >= 30 || dy < 2 || dy >= 30) return 24'hFFFFFF;
            return palette(color_of(moves));
        end
        return 24'h000040;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic probe(input string name, input int x, input int y);
        bus.x_val = 10'(x);
        bus.y_val = 10'(y);
        @(posedge clk); #1;
        check(name, {8'h0, bus.red, bus.green, bus.blue}, {8'h0, model_rgb(x, y)});
    endtask

    task automatic tick();
        bus.vsync_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.vsync_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        frames = (frames + 1) % 65536;
        if (bus.enable) moves++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_probes(input int n);
        int bx, by, x, y;
        bx = tri_pos(moves, 608);
        by = tri_pos(moves, 448);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1) == 1) begin
                x = bx + int'($urandom_range(40)) - 4;
                y = by + int'($urandom_range(40)) - 4;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end else begin
                x = int'($urandom_range(700));
                y = int'($urandom_range(520));
            end
            probe("rand_pixel", x, y);
        end
    endtask

    initial begin
        vecs[0] = '{10'd0,   10'd0,   24'hFFFFFF};
        vecs[1] = '{10'd10,  10'd10,  24'hFF0000};
        vecs[2] = '{10'd100, 10'd100, 24'h000040};
        vecs[3] = '{10'd640, 10'd100, 24'h000000};
        vecs[4] = '{10'd100, 10'd480, 24'h000000};
        vecs[5] = '{10'd31,  10'd31,  24'hFFFFFF};
        vecs[6] = '{10'd29,  10'd2,   24'hFF0000};
        vecs[7] = '{10'd32,  10'd0,   24'h000040};

        rst_n        = 1'b0;
        bus.x_val    = '0;
        bus.y_val    = '0;
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        bus.enable   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hsync_out", 32'(bus.hsync_out), 32'd1);
        check("reset_vsync_out", 32'(bus.vsync_out), 32'd1);
        check("reset_rgb", {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
        check("reset_frame_count", 32'(bus.frame_count), 32'd0);

        bus.vsync_in = 1'b1;
        bus.hsync_in = 1'b1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            bus.x_val = vecs[i].x;
            bus.y_val = vecs[i].y;
            @(posedge clk); #1;
            check($sformatf("vec%0d_rgb", i), {8'h0, bus.red, bus.green, bus.blue},
                  {8'h0, vecs[i].rgb});
        end

        bus.hsync_in = 1'b0;
        #1;
        check("hsync_before_edge", 32'(bus.hsync_out), 32'd1);
        @(posedge clk); #1;
        check("hsync_follow_low", 32'(bus.hsync_out), 32'd0);
        bus.hsync_in = 1'b1;
        @(posedge clk); #1;
        check("hsync_follow_high", 32'(bus.hsync_out), 32'd1);
        check("no_tick_after_reset", 32'(bus.frame_count), 32'd0);

        tick();
        check("first_tick_count", 32'(bus.frame_count), 32'(frames));
        probe("pix_1_1_after_tick", 1, 1);
        probe("pix_2_2_after_tick", 2, 2);
        check("pix_2_2_is_border", {8'h0, bus.red, bus.green, bus.blue}, 32'h00FFFFFF);

        ticks(223);
        probe("bottom_bounce_interior", 448 + 16, 448 + 16);
        check("bottom_bounce_green", {8'h0, bus.red, bus.green, bus.blue}, 32'h0000FF00);
        probe("below_box_bg", 464, 479);
        rand_probes(20);

        ticks(80);
        probe("right_bounce_interior", 608 + 16, 288 + 16);
        check("right_bounce_blue", {8'h0, bus.red, bus.green, bus.blue}, 32'h000000FF);
        probe("box_right_edge_border", 639, 300);
        rand_probes(20);

        bus.enable = 1'b0;
        ticks(10);
        check("disabled_frame_count", 32'(bus.frame_count), 32'(frames));
        probe("disabled_interior", 608 + 16, 288 + 16);
        rand_probes(10);
        bus.enable = 1'b1;

        bus.vsync_in = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        bus.vsync_in = 1'b1;
        frames = (frames + 1) % 65536;
        moves++;
        @(posedge clk); #1;
        check("long_vsync_one_tick", 32'(bus.frame_count), 32'(frames));
        rand_probes(10);

        ticks(137);
        rand_probes(30);
        check("frame_count_later", 32'(bus.frame_count), 32'(frames));

        bus.x_val = 10'(tri_pos(moves, 608) + 16);
        bus.y_val = 10'(tri_pos(moves, 448) + 16);
        bus.vsync_in = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midframe_reset_rgb", {8'h0, bus.red, bus.green, bus.blue}, 32'h0);
        check("midframe_reset_count", 32'(bus.frame_count), 32'd0);
        check("midframe_reset_vsync_out", 32'(bus.vsync_out), 32'd1);
        bus.vsync_in = 1'b1;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        moves  = 0;
        frames = 0;
        probe("post_reset_origin", 0, 0);
        probe("post_reset_interior", 10, 10);
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_no_tick", 32'(bus.frame_count), 32'd0);
        tick();
        check("post_reset_tick", 32'(bus.frame_count), 32'd1);
        probe("post_reset_moved", 2, 2);
        probe("post_reset_bg", 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
